// File: rtl/flag_ctrl_pkg.sv
// Shared constants and types for the N/V/Z flag controller: opcodes,
// branch condition codes, flag bit positions and the branch FSM state type.
package flag_ctrl_pkg;

    // EX opcodes that touch the flag register
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRA = 4'b0101;
    localparam logic [3:0] OP_ROR = 4'b0110;

    // Branch condition codes (ccc)
    localparam logic [2:0] CC_NE = 3'b000;
    localparam logic [2:0] CC_EQ = 3'b001;
    localparam logic [2:0] CC_GT = 3'b010;
    localparam logic [2:0] CC_LT = 3'b011;
    localparam logic [2:0] CC_GE = 3'b100;
    localparam logic [2:0] CC_LE = 3'b101;
    localparam logic [2:0] CC_OV = 3'b110;
    localparam logic [2:0] CC_UN = 3'b111;

    // Bit positions inside the architectural flag register
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_Z = 0;

    // Bit positions inside the raw ALU flag bus (and the write-enable mask)
    localparam int ALU_N = 0;
    localparam int ALU_V = 1;
    localparam int ALU_Z = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/flag_ctrl_reg.sv
// Three-bit flag register with an independent write enable per bit.
// Bit order is the architectural one: [2]=N [1]=V [0]=Z.
module flag_reg (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] wen,
    input  logic [2:0] din,
    output logic [2:0] q
);

    // Each flag bit loads its new value only when its own enable is set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 3'b000;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (wen[i]) begin
                    q[i] <= din[i];
                end
            end
        end
    end

endmodule

// File: rtl/flag_ctrl.sv
// Flag controller: decodes which flags the EX instruction writes, owns the
// flag register, and resolves ID-stage conditional branches, stalling one
// cycle on a flag hazard unless EX flags are forwarded.
module flag_ctrl
    import flag_ctrl_pkg::*;
#(
    parameter int OPW     = 4,
    parameter int FORWARD = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ex_valid,
    input  logic           ex_stall,
    input  logic [OPW-1:0] ex_opcode,
    input  logic [2:0]     alu_nvz,
    input  logic           br_valid,
    input  logic [2:0]     br_cond,
    input  logic           flush,
    output logic [2:0]     flags,
    output logic           br_stall,
    output logic           br_resolved,
    output logic           br_taken
);

    state_t     state;
    state_t     state_next;
    logic [2:0] wen_alu;
    logic [2:0] wen_reg;
    logic [2:0] din_reg;
    logic [2:0] merged;
    logic       hz;

    // Write mask in ALU bit order: ADD/SUB write all flags, shifts/XOR only Z
    function automatic logic [2:0] decode_wen(input logic [OPW-1:0] op);
        logic [2:0] w;
        case (op)
            OPW'(OP_ADD), OPW'(OP_SUB): w = 3'b111;
            OPW'(OP_XOR), OPW'(OP_SLL),
            OPW'(OP_SRA), OPW'(OP_ROR): w = 3'b100;
            default:                    w = 3'b000;
        endcase
        return w;
    endfunction

    // Evaluates a condition code against flags in register bit order
    function automatic logic cond_eval(input logic [2:0] cc, input logic [2:0] f);
        logic n;
        logic v;
        logic z;
        logic r;
        n = f[FLAG_N];
        v = f[FLAG_V];
        z = f[FLAG_Z];
        case (cc)
            CC_NE:   r = ~z;
            CC_EQ:   r = z;
            CC_GT:   r = ~z & ~n;
            CC_LT:   r = n;
            CC_GE:   r = z | (~z & ~n);
            CC_LE:   r = n | z;
            CC_OV:   r = v;
            default: r = 1'b1;
        endcase
        return r;
    endfunction

    // Write enables, reordered data, forwarded view of the flags and the hazard
    always_comb begin
        wen_alu = (ex_valid & ~ex_stall) ? decode_wen(ex_opcode) : 3'b000;
        wen_reg = {wen_alu[ALU_N], wen_alu[ALU_V], wen_alu[ALU_Z]};
        din_reg = {alu_nvz[ALU_N], alu_nvz[ALU_V], alu_nvz[ALU_Z]};
        merged  = (din_reg & wen_reg) | (flags & ~wen_reg);
        hz      = br_valid & (wen_alu != 3'b000);
    end

    flag_reg u_flag_reg (
        .clk (clk),
        .rst (rst),
        .wen (wen_reg),
        .din (din_reg),
        .q   (flags)
    );

    // Branch FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Enter HOLD only on an unforwarded hazard; HOLD always lasts one cycle
    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (hz && (FORWARD == 0)) begin
                        state_next = ST_HOLD;
                    end
                end
                ST_HOLD: state_next = ST_IDLE;
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Branch outputs; forced low during reset so a held branch is dropped at once
    always_comb begin
        br_stall    = 1'b0;
        br_resolved = 1'b0;
        br_taken    = 1'b0;
        if (!rst && !flush) begin
            case (state)
                ST_IDLE: begin
                    if (br_valid) begin
                        if (!hz) begin
                            br_resolved = 1'b1;
                            br_taken    = cond_eval(br_cond, flags);
                        end else if (FORWARD != 0) begin
                            br_resolved = 1'b1;
                            br_taken    = cond_eval(br_cond, merged);
                        end else begin
                            br_stall    = 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    br_resolved = 1'b1;
                    br_taken    = cond_eval(br_cond, flags);
                end
                default: ;
            endcase
        end
    end

endmodule
